// File: rtl/game_pkg.sv
// Shared encodings and defaults for the fighting-game match logic; also
// consumed by the render and HEX display blocks.
package game_pkg;

  typedef enum logic [1:0] {
    PH_FIGHT      = 2'b00,
    PH_KO_PAUSE   = 2'b01,
    PH_MATCH_OVER = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int DEF_HEALTH_W     = 3;
  localparam int DEF_MAX_HEALTH   = 5;
  localparam int DEF_DAMAGE       = 1;
  localparam int DEF_INVULN_TICKS = 8;
  localparam int DEF_PAUSE_TICKS  = 60;
  localparam int DEF_ROUNDS_WIN   = 2;
  localparam int DEF_ROUND_W      = 2;

  function automatic winner_t winner_of(input logic p1_won);
    if (p1_won) begin
      return WIN_P1;
    end else begin
      return WIN_P2;
    end
  endfunction

endpackage

// File: rtl/player_vitals.sv
// One player's health and invulnerability window; decides whether an incoming
// strike is accepted and exposes the post-hit health for KO detection.
module player_vitals
  import game_pkg::*;
#(
  parameter int HEALTH_W     = DEF_HEALTH_W,
  parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
  parameter int DAMAGE       = DEF_DAMAGE,
  parameter int INVULN_TICKS = DEF_INVULN_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                hit_lands,
  input  logic                hit_enable,
  input  logic                restore,
  output logic [HEALTH_W-1:0] health,
  output logic [HEALTH_W-1:0] health_next
);

  localparam int INV_W = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;
  localparam logic [HEALTH_W-1:0] MAX_L    = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] DMG_L    = HEALTH_W'(DAMAGE);
  localparam logic [HEALTH_W-1:0] H_ZERO   = {HEALTH_W{1'b0}};
  localparam logic [INV_W-1:0]    INV_L    = INV_W'(INVULN_TICKS);
  localparam logic [INV_W-1:0]    INV_ZERO = {INV_W{1'b0}};
  localparam logic [INV_W-1:0]    INV_ONE  = INV_W'(1);

  logic [HEALTH_W-1:0] health_r;
  logic [HEALTH_W-1:0] health_next_s;
  logic [INV_W-1:0]    inv_r;
  logic                accept_s;

  // Hit acceptance and saturating damage
  always_comb begin
    accept_s      = 1'b0;
    health_next_s = health_r;
    if (tick && hit_enable && hit_lands && (inv_r == INV_ZERO)) begin
      accept_s = 1'b1;
      if (health_r > DMG_L) begin
        health_next_s = health_r - DMG_L;
      end else begin
        health_next_s = H_ZERO;
      end
    end else begin
      accept_s      = 1'b0;
      health_next_s = health_r;
    end
  end

  // Health and invulnerability state; the window keeps draining in every phase
  always_ff @(posedge clk) begin
    if (reset) begin
      health_r <= MAX_L;
      inv_r    <= INV_ZERO;
    end else if (tick) begin
      if (restore) begin
        health_r <= MAX_L;
        inv_r    <= INV_ZERO;
      end else begin
        health_r <= health_next_s;
        if (accept_s) begin
          inv_r <= INV_L;
        end else if (inv_r != INV_ZERO) begin
          inv_r <= inv_r - INV_ONE;
        end
      end
    end
  end

  assign health      = health_r;
  assign health_next = health_next_s;

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: scores KOs, runs the pause between rounds and
// latches the match result.
module match_controller
  import game_pkg::*;
#(
  parameter int HEALTH_W      = DEF_HEALTH_W,
  parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
  parameter int DAMAGE        = DEF_DAMAGE,
  parameter int INVULN_TICKS  = DEF_INVULN_TICKS,
  parameter int PAUSE_TICKS   = DEF_PAUSE_TICKS,
  parameter int ROUNDS_TO_WIN = DEF_ROUNDS_WIN,
  parameter int ROUND_W       = DEF_ROUND_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                hit1_lands,
  input  logic                hit2_lands,
  output logic [HEALTH_W-1:0] health1,
  output logic [HEALTH_W-1:0] health2,
  output logic [ROUND_W-1:0]  rounds1,
  output logic [ROUND_W-1:0]  rounds2,
  output logic [1:0]          phase,
  output logic                round_active,
  output logic                game_over1,
  output logic                game_over2,
  output logic [1:0]          winner
);

  localparam int PAUSE_W = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;
  localparam logic [PAUSE_W-1:0]  PAUSE_L    = PAUSE_W'(PAUSE_TICKS);
  localparam logic [PAUSE_W-1:0]  PAUSE_ZERO = {PAUSE_W{1'b0}};
  localparam logic [PAUSE_W-1:0]  PAUSE_ONE  = PAUSE_W'(1);
  localparam logic [ROUND_W-1:0]  RTW_L      = ROUND_W'(ROUNDS_TO_WIN);
  localparam logic [ROUND_W-1:0]  ROUND_ZERO = {ROUND_W{1'b0}};
  localparam logic [ROUND_W-1:0]  ROUND_ONE  = ROUND_W'(1);
  localparam logic [HEALTH_W-1:0] H_ZERO     = {HEALTH_W{1'b0}};

  phase_t              phase_r;
  winner_t             winner_r;
  logic                round_active_r;
  logic                game_over1_r;
  logic                game_over2_r;
  logic [PAUSE_W-1:0]  pause_r;
  logic [ROUND_W-1:0]  rounds1_r;
  logic [ROUND_W-1:0]  rounds2_r;
  logic [HEALTH_W-1:0] p1_next_s;
  logic [HEALTH_W-1:0] p2_next_s;
  logic                fight_s;
  logic                restore_s;
  logic                match_won_s;
  logic                ko1_s;
  logic                ko2_s;

  // Phase decode shared by both vitals blocks and the FSM
  always_comb begin
    fight_s     = (phase_r == PH_FIGHT);
    match_won_s = (rounds1_r == RTW_L) || (rounds2_r == RTW_L);
    ko1_s       = (p1_next_s == H_ZERO);
    ko2_s       = (p2_next_s == H_ZERO);
    restore_s   = 1'b0;
    if ((phase_r == PH_KO_PAUSE) && (pause_r == PAUSE_ZERO) && !match_won_s) begin
      restore_s = 1'b1;
    end else begin
      restore_s = 1'b0;
    end
  end

  // Player 1 takes damage from player 2's strikes and vice versa
  player_vitals #(
    .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH),
    .DAMAGE(DAMAGE), .INVULN_TICKS(INVULN_TICKS)
  ) u_p1 (
    .clk(clk), .reset(reset), .tick(tick), .hit_lands(hit2_lands),
    .hit_enable(fight_s), .restore(restore_s),
    .health(health1), .health_next(p1_next_s)
  );

  player_vitals #(
    .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH),
    .DAMAGE(DAMAGE), .INVULN_TICKS(INVULN_TICKS)
  ) u_p2 (
    .clk(clk), .reset(reset), .tick(tick), .hit_lands(hit1_lands),
    .hit_enable(fight_s), .restore(restore_s),
    .health(health2), .health_next(p2_next_s)
  );

  // Round FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r        <= PH_FIGHT;
      round_active_r <= 1'b1;
      pause_r        <= PAUSE_ZERO;
      rounds1_r      <= ROUND_ZERO;
      rounds2_r      <= ROUND_ZERO;
      winner_r       <= WIN_NONE;
      game_over1_r   <= 1'b0;
      game_over2_r   <= 1'b0;
    end else if (tick) begin
      case (phase_r)
        PH_FIGHT: begin
          if (ko1_s || ko2_s) begin
            phase_r        <= PH_KO_PAUSE;
            round_active_r <= 1'b0;
            pause_r        <= PAUSE_L;
            // A double KO is a draw and scores nobody
            if (ko2_s && !ko1_s && (rounds1_r < RTW_L)) begin
              rounds1_r <= rounds1_r + ROUND_ONE;
            end
            if (ko1_s && !ko2_s && (rounds2_r < RTW_L)) begin
              rounds2_r <= rounds2_r + ROUND_ONE;
            end
          end
        end
        PH_KO_PAUSE: begin
          if (pause_r != PAUSE_ZERO) begin
            pause_r <= pause_r - PAUSE_ONE;
          end else if (match_won_s) begin
            phase_r      <= PH_MATCH_OVER;
            winner_r     <= winner_of(rounds1_r == RTW_L);
            game_over1_r <= (rounds2_r == RTW_L);
            game_over2_r <= (rounds1_r == RTW_L);
          end else begin
            phase_r        <= PH_FIGHT;
            round_active_r <= 1'b1;
          end
        end
        PH_MATCH_OVER: begin
          phase_r <= PH_MATCH_OVER;
        end
        default: begin
          phase_r        <= PH_FIGHT;
          round_active_r <= 1'b1;
        end
      endcase
    end
  end

  assign rounds1      = rounds1_r;
  assign rounds2      = rounds2_r;
  assign phase        = phase_r;
  assign round_active = round_active_r;
  assign game_over1   = game_over1_r;
  assign game_over2   = game_over2_r;
  assign winner       = winner_r;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: vector table for the held-strike
// pattern plus directed round, draw, match-over, idle and reset sequences.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       hit1_lands;
  logic       hit2_lands;
  logic [2:0] health1;
  logic [2:0] health2;
  logic [1:0] rounds1;
  logic [1:0] rounds2;
  logic [1:0] phase;
  logic       round_active;
  logic       game_over1;
  logic       game_over2;
  logic [1:0] winner;

  always #5 clk = ~clk;

  match_controller dut (
    .clk(clk), .reset(reset), .tick(tick),
    .hit1_lands(hit1_lands), .hit2_lands(hit2_lands),
    .health1(health1), .health2(health2),
    .rounds1(rounds1), .rounds2(rounds2),
    .phase(phase), .round_active(round_active),
    .game_over1(game_over1), .game_over2(game_over2),
    .winner(winner)
  );

  typedef struct packed {
    logic [2:0] h1;
    logic [2:0] h2;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] ph;
    logic       ra;
    logic       go1;
    logic       go2;
    logic [1:0] win;
  } outs_t;

  typedef struct {
    logic  tk;
    logic  a;
    logic  b;
    outs_t exp;
  } vec_t;

  outs_t exp_q[$];
  string name_q[$];
  vec_t  vecs[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic outs_t mk(input logic [2:0] h1, input logic [2:0] h2,
                               input logic [1:0] r1, input logic [1:0] r2,
                               input logic [1:0] ph, input logic [1:0] win);
    outs_t o;
    o.h1 = h1; o.h2 = h2; o.r1 = r1; o.r2 = r2; o.ph = ph;
    o.ra  = (ph == 2'b00);
    o.go1 = (win == 2'b10);
    o.go2 = (win == 2'b01);
    o.win = win;
    return o;
  endfunction

  function automatic outs_t sample_dut();
    outs_t o;
    o.h1 = health1; o.h2 = health2; o.r1 = rounds1; o.r2 = rounds2;
    o.ph = phase; o.ra = round_active; o.go1 = game_over1; o.go2 = game_over2;
    o.win = winner;
    return o;
  endfunction

  task automatic check_out();
    outs_t e;
    outs_t a;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = sample_dut();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got h1=%0d h2=%0d r1=%0d r2=%0d ph=%b ra=%b go=%b%b win=%b, expected h1=%0d h2=%0d r1=%0d r2=%0d ph=%b ra=%b go=%b%b win=%b",
               nm, a.h1, a.h2, a.r1, a.r2, a.ph, a.ra, a.go1, a.go2, a.win,
               e.h1, e.h2, e.r1, e.r2, e.ph, e.ra, e.go1, e.go2, e.win);
    end
  endtask

  task automatic step(input logic tk, input logic a, input logic b,
                      input outs_t e, input string nm);
    tick = tk; hit1_lands = a; hit2_lands = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    tick = 1'b0; hit1_lands = 1'b0; hit2_lands = 1'b0;
    check_out();
  endtask

  task automatic do_reset(input logic tk, input logic a, input string nm);
    reset = 1'b1; tick = tk; hit1_lands = a; hit2_lands = a;
    exp_q.push_back(mk(3'd5, 3'd5, 2'd0, 2'd0, 2'b00, 2'b00));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    reset = 1'b0; tick = 1'b0; hit1_lands = 1'b0; hit2_lands = 1'b0;
    check_out();
  endtask

  // Five strikes ten ticks apart from full health; r1/r2 are the scores before the round
  task automatic play_round(input logic s1, input logic s2,
                            input logic [1:0] r1, input logic [1:0] r2, input string nm);
    logic [2:0] h;
    logic [2:0] hp1;
    logic [2:0] hp2;
    logic [1:0] nr1;
    logic [1:0] nr2;
    for (int s = 0; s < 5; s++) begin
      h   = 3'(4 - s);
      hp1 = s2 ? h : 3'd5;
      hp2 = s1 ? h : 3'd5;
      if (s < 4) begin
        step(1'b1, s1, s2, mk(hp1, hp2, r1, r2, 2'b00, 2'b00), nm);
        for (int k = 0; k < 9; k++) begin
          step(1'b1, 1'b0, 1'b0, mk(hp1, hp2, r1, r2, 2'b00, 2'b00), nm);
        end
      end else begin
        nr1 = (s1 && !s2) ? r1 + 2'd1 : r1;
        nr2 = (s2 && !s1) ? r2 + 2'd1 : r2;
        step(1'b1, s1, s2, mk(hp1, hp2, nr1, nr2, 2'b01, 2'b00), nm);
      end
    end
  endtask

  // Sixty pause ticks with strikes thrown, then the leaving tick
  task automatic ride_pause(input outs_t e_pause, input outs_t e_after, input string nm);
    for (int k = 0; k < 60; k++) begin
      step(1'b1, k[0], k[1], e_pause, nm);
    end
    step(1'b1, 1'b1, 1'b1, e_after, {nm, "_exit"});
  endtask

  initial begin
    logic [2:0] h2e;
    vec_t       v;
    outs_t      hold;

    reset = 1'b1; tick = 1'b0; hit1_lands = 1'b0; hit2_lands = 1'b0;
    for (int i = 0; i < 20; i++) begin
      h2e   = 3'(5 - 1 - ((i >= 9) ? 1 : 0) - ((i >= 18) ? 1 : 0));
      v.tk  = 1'b1; v.a = 1'b1; v.b = 1'b0;
      v.exp = mk(3'd5, h2e, 2'd0, 2'd0, 2'b00, 2'b00);
      vecs.push_back(v);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with tick and strikes asserted to show reset dominates
    do_reset(1'b1, 1'b1, "reset_state");

    // Held strike: accepted on ticks 0, 9 and 18 only
    foreach (vecs[i]) begin
      step(vecs[i].tk, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("held_hit_%0d", i));
    end

    // P1 wins a round, pause, fresh round
    do_reset(1'b0, 1'b0, "reset2");
    play_round(1'b1, 1'b0, 2'd0, 2'd0, "p1_round");
    ride_pause(mk(3'd5, 3'd0, 2'd1, 2'd0, 2'b01, 2'b00),
               mk(3'd5, 3'd5, 2'd1, 2'd0, 2'b00, 2'b00), "p1_pause");

    // Double KO is a draw
    do_reset(1'b0, 1'b0, "reset3");
    play_round(1'b1, 1'b1, 2'd0, 2'd0, "draw_round");
    ride_pause(mk(3'd0, 3'd0, 2'd0, 2'd0, 2'b01, 2'b00),
               mk(3'd5, 3'd5, 2'd0, 2'd0, 2'b00, 2'b00), "draw_pause");

    // P2 takes the match; MATCH_OVER is frozen
    do_reset(1'b0, 1'b0, "reset4");
    play_round(1'b0, 1'b1, 2'd0, 2'd0, "p2_round1");
    ride_pause(mk(3'd0, 3'd5, 2'd0, 2'd1, 2'b01, 2'b00),
               mk(3'd5, 3'd5, 2'd0, 2'd1, 2'b00, 2'b00), "p2_pause1");
    play_round(1'b0, 1'b1, 2'd0, 2'd1, "p2_round2");
    hold = mk(3'd0, 3'd5, 2'd0, 2'd2, 2'b10, 2'b10);
    ride_pause(mk(3'd0, 3'd5, 2'd0, 2'd2, 2'b01, 2'b00), hold, "p2_pause2");
    for (int k = 0; k < 12; k++) begin
      step(1'b1, k[0], ~k[0], hold, "match_over_frozen");
    end

    // tick low freezes everything, including the invulnerability window
    do_reset(1'b0, 1'b0, "reset5");
    hold = mk(3'd5, 3'd4, 2'd0, 2'd0, 2'b00, 2'b00);
    step(1'b1, 1'b1, 1'b0, hold, "idle_first_hit");
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hold, "idle_hold");
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, hold, "idle_inv_still");
    end
    step(1'b1, 1'b1, 1'b0, mk(3'd5, 3'd3, 2'd0, 2'd0, 2'b00, 2'b00), "idle_inv_expired");

    // Reset during KO_PAUSE abandons the round and the invulnerability window
    do_reset(1'b0, 1'b0, "reset6");
    play_round(1'b1, 1'b0, 2'd0, 2'd0, "pre_abort_round");
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, mk(3'd5, 3'd0, 2'd1, 2'd0, 2'b01, 2'b00), "pre_abort_pause");
    end
    do_reset(1'b1, 1'b1, "reset_mid_pause");
    step(1'b1, 1'b1, 1'b0, mk(3'd5, 3'd4, 2'd0, 2'd0, 2'b00, 2'b00), "post_reset_hit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
